// File: rtl/uart_receive.sv
// uart_receive: start/data/stop UART deserialiser with a one-entry valid/ready output register.
// Optional 2-flop rx synchroniser enabled by defining UART_RX_SYNC_EN.
module uart_receive #(
    parameter int D_WIDTH      = 16,
    parameter int C_WIDTH      = 5,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               overrun
);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [C_WIDTH-1:0] idx, idx_n;
    logic [D_WIDTH-1:0] sh, sh_n;
    logic rxs, tick, frame_ok, frame_bad;
`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk)
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    assign rxs = sync[1];
`else
    assign rxs = rx;
`endif
    assign tick    = cnt == 8'(CLKS_PER_BIT - 1);
    assign rx_busy = (state == START) || (state == DATA) || (state == STOP);
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 8'd1;
        idx_n     = idx;
        sh_n      = sh;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: if (!rxs) begin
                // with HALF=0 the start bit is confirmed on the very cycle it is seen
                state_n = (HALF == 0) ? DATA : START;
                cnt_n   = (HALF == 0) ? 8'd0 : 8'd1;
                idx_n   = '0;
            end
            START: if (cnt == 8'(HALF)) begin
                state_n = rxs ? IDLE : DATA;
                cnt_n   = 8'd0;
                idx_n   = '0;
            end
            DATA: if (tick) begin
                sh_n    = {rxs, sh[D_WIDTH-1:1]};
                cnt_n   = 8'd0;
                idx_n   = idx + C_WIDTH'(1);
                state_n = (idx == C_WIDTH'(D_WIDTH - 1)) ? STOP : DATA;
            end
            STOP: if (tick) begin
                cnt_n     = 8'd0;
                frame_ok  = rxs;
                frame_bad = !rxs;
                state_n   = rxs ? IDLE : BREAK;
            end
            BREAK: if (rxs) state_n = IDLE;
            default: state_n = BREAK;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            state     <= BREAK;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            frame_err <= frame_bad;
            overrun   <= frame_ok && rx_valid && !rx_ready;
            if (frame_ok && (!rx_valid || rx_ready)) begin
                rx_data  <= sh;
                rx_valid <= 1'b1;
            end else if (rx_ready) rx_valid <= 1'b0;
        end
endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed, table-driven bench for uart_receive at 1 and 4 clocks per bit.
module tb_uart_receive;
`ifdef UART_RX_SYNC_EN
    localparam int SYN = 2;
`else
    localparam int SYN = 0;
`endif
    logic clk = 0, rst = 1;
    logic rx1 = 1, rdy1 = 1, rx4 = 1, rdy4 = 0;
    logic [15:0] d1, d4;
    logic v1, b1, fe1, ov1, v4, b4, fe4, ov4;
    int tests = 0, fails = 0;

    uart_receive #(.D_WIDTH(16), .C_WIDTH(5), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .rx_busy(b1), .frame_err(fe1), .overrun(ov1));
    uart_receive #(.D_WIDTH(16), .C_WIDTH(5), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .rx_data(d4), .rx_valid(v4), .rx_ready(rdy4),
        .rx_busy(b4), .frame_err(fe4), .overrun(ov4));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic stop, ready, ev;
        logic [15:0] ed;
        logic ef, eo;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc1(input logic r);
        rx1 = r;
        @(posedge clk); #1;
    endtask

    task automatic cyc4(input logic r);
        rx4 = r;
        @(posedge clk); #1;
    endtask

    task automatic send1(input logic [15:0] d, input logic stop, input logic chk_busy);
        for (int k = 0; k < 18; k++) begin
            if (chk_busy) chk($sformatf("busy_t%0d", k), b1, (k >= 1 + SYN) && (k <= 17 + SYN));
            cyc1(k == 0 ? 1'b0 : (k == 17 ? stop : d[k-1]));
        end
    endtask

    task automatic send4(input logic [15:0] d);
        repeat (4) cyc4(0);
        for (int i = 0; i < 16; i++) repeat (4) cyc4(d[i]);
        repeat (4) cyc4(1);
        repeat (SYN) cyc4(1);
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 1'b1, 1'b1, 1'b1, 16'hA5C3, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{16'h8001, 1'b1, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b0};
        vecs[4] = '{16'h1234, 1'b0, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b0};
        vecs[5] = '{16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h5A5A, 1'b1, 1'b0, 1'b1, 16'h5A5A, 1'b0, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", d1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_busy", b1, 0);
        chk("rst_ferr", fe1, 0);
        chk("rst_ovr", ov1, 0);
        rst = 0;
        repeat (4) cyc1(1);
        // basic frame with busy window and a single-cycle valid
        rdy1 = 1;
        send1(16'hA5C3, 1'b1, 1'b1);
        repeat (SYN) cyc1(1);
        chk("t1_busy_end", b1, 0);
        chk("t1_valid", v1, 1);
        chk("t1_data", d1, 16'hA5C3);
        cyc1(1);
        chk("t1_valid_drop", v1, 0);
        chk("t1_data_hold", d1, 16'hA5C3);
        for (int i = 0; i < 7; i++) begin
            rdy1 = vecs[i].ready;
            send1(vecs[i].d, vecs[i].stop, 1'b0);
            repeat (SYN) cyc1(vecs[i].stop);
            chk($sformatf("vec%0d_valid", i), v1, vecs[i].ev);
            chk($sformatf("vec%0d_data", i), d1, vecs[i].ed);
            chk($sformatf("vec%0d_ferr", i), fe1, vecs[i].ef);
            chk($sformatf("vec%0d_ovr", i), ov1, vecs[i].eo);
            rdy1 = 1;
            repeat (3) cyc1(1);
        end
        // stop bit low then line held low: no retrigger until it returns high
        send1(16'hA5C3, 1'b0, 1'b0);
        repeat (SYN) cyc1(0);
        chk("t2_ferr", fe1, 1);
        chk("t2_valid", v1, 0);
        for (int k = 0; k < 4; k++) begin
            cyc1(0);
            chk($sformatf("t2_break_busy%0d", k), b1, 0);
            chk($sformatf("t2_break_ferr%0d", k), fe1, 0);
        end
        cyc1(1);
        send1(16'h0001, 1'b1, 1'b0);
        repeat (SYN) cyc1(1);
        chk("t2_next_valid", v1, 1);
        chk("t2_next_data", d1, 16'h0001);
        repeat (3) cyc1(1);
        // back-to-back frames into a full holding register
        rdy1 = 0;
        send1(16'h1234, 1'b1, 1'b0);
        send1(16'h5678, 1'b1, 1'b0);
        repeat (SYN) cyc1(1);
        chk("t3_valid", v1, 1);
        chk("t3_data", d1, 16'h1234);
        chk("t3_ovr", ov1, 1);
        cyc1(1);
        chk("t3_ovr_pulse", ov1, 0);
        chk("t3_valid_kept", v1, 1);
        rdy1 = 1;
        cyc1(1);
        chk("t3_valid_drop", v1, 0);
        chk("t3_data_hold", d1, 16'h1234);
        // 4 clocks per bit: short glitch, then full frames
        repeat (3) cyc4(1);
        cyc4(0);
        repeat (SYN) cyc4(1);
        chk("t4_start_busy", b4, 1);
        cyc4(1);
        chk("t4_glitch_busy", b4, 0);
        repeat (6) cyc4(1);
        chk("t4_glitch_valid", v4, 0);
        chk("t4_glitch_ferr", fe4, 0);
        chk("t4_glitch_ovr", ov4, 0);
        send4(16'hFFFF);
        chk("t4_ffff_valid", v4, 1);
        chk("t4_ffff_data", d4, 16'hFFFF);
        rdy4 = 1;
        cyc4(1);
        rdy4 = 0;
        chk("t4_drain", v4, 0);
        send4(16'h3C96);
        chk("t4_3c96_valid", v4, 1);
        chk("t4_3c96_data", d4, 16'h3C96);
        chk("t4_3c96_ferr", fe4, 0);
        // reset in the middle of a frame with the line held low afterwards
        cyc1(0);
        for (int i = 0; i < 8; i++) cyc1(i[0]);
        rst = 1;
        cyc1(0);
        cyc1(0);
        chk("t5_data", d1, 0);
        chk("t5_valid", v1, 0);
        chk("t5_busy", b1, 0);
        chk("t5_ferr", fe1, 0);
        chk("t5_ovr", ov1, 0);
        rst = 0;
        repeat (25) cyc1(0);
        chk("t5_low_busy", b1, 0);
        chk("t5_low_valid", v1, 0);
        chk("t5_low_ferr", fe1, 0);
        repeat (2) cyc1(1);
        rdy1 = 0;
        send1(16'hC33C, 1'b1, 1'b0);
        repeat (SYN) cyc1(1);
        chk("t5_after_valid", v1, 1);
        chk("t5_after_data", d1, 16'hC33C);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
